// File: rtl/write_driver_seq.sv
// Sequenced SRAM column write driver: precharge -> drive -> recover on each accepted
// write, with per-column masking and a wordline strobe aligned to the drive phase.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bitlines precharged, ready for a request
// PRECHARGE | all bitlines held at VDD for PRE_CYCLES
// DRIVE     | wl_en high, masked columns driven from data_q for DRIVE_CYCLES
// RECOVER   | bitlines back to VDD, done pulsed, returns to IDLE
module write_driver_seq #(
  parameter int  COLS         = 8,
  parameter int  PRE_CYCLES   = 1,
  parameter int  DRIVE_CYCLES = 2,
  parameter real VDD          = 1.0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_req,
  output logic            wr_ready,
  input  logic [COLS-1:0] data_in,
  input  logic [COLS-1:0] wmask,
  output logic            wl_en,
  output logic            busy,
  output logic            done,
  output real             bl_wr  [COLS],
  output real             blb_wr [COLS]
);

  localparam int MAXC = (PRE_CYCLES > DRIVE_CYCLES) ? PRE_CYCLES : DRIVE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] PRE_LD = CW'(PRE_CYCLES - 1);
  localparam logic [CW-1:0] DRV_LD = CW'(DRIVE_CYCLES - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRECHARGE = 2'd1,
    DRIVE     = 2'd2,
    RECOVER   = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [COLS-1:0] data_q;
  logic [COLS-1:0] mask_q;
  logic [COLS-1:0] bl_q;
  logic [COLS-1:0] blb_q;

  // Drive pattern: unmasked columns stay precharged on both rails.
  logic [COLS-1:0] bl_drv;
  logic [COLS-1:0] blb_drv;
  assign bl_drv  = ~mask_q | data_q;
  assign blb_drv = ~mask_q | ~data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      mask_q <= '0;
      wl_en  <= 1'b0;
      done   <= 1'b0;
      bl_q   <= '1;
      blb_q  <= '1;
    end else begin
      wl_en <= 1'b0;
      done  <= 1'b0;
      bl_q  <= '1;
      blb_q <= '1;
      case (state)
        IDLE: begin
          if (wr_req) begin
            data_q <= data_in;
            mask_q <= wmask;
            cnt    <= PRE_LD;
            state  <= PRECHARGE;
          end
        end
        PRECHARGE: begin
          if (cnt == '0) begin
            cnt   <= DRV_LD;
            state <= DRIVE;
            wl_en <= 1'b1;
            bl_q  <= bl_drv;
            blb_q <= blb_drv;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            state <= RECOVER;
            done  <= 1'b1;
          end else begin
            cnt   <= cnt - ONE;
            wl_en <= 1'b1;
            bl_q  <= bl_drv;
            blb_q <= blb_drv;
          end
        end
        RECOVER: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  for (genvar i = 0; i < COLS; i++) begin : g_lvl
    assign bl_wr[i]  = bl_q[i]  ? VDD : 0.0;
    assign blb_wr[i] = blb_q[i] ? VDD : 0.0;
  end

endmodule

// File: tb/tb_write_driver_seq.sv
// Directed bench for write_driver_seq: default instance (P=1, D=2) and a P=3, D=4 instance.
module tb_write_driver_seq;

  logic       clk;
  logic       rst_n;

  logic       wr_req0, wr_ready0, wl_en0, busy0, done0;
  logic [7:0] data0, mask0;
  real        bl0 [8];
  real        blb0 [8];

  logic       wr_req1, wr_ready1, wl_en1, busy1, done1;
  logic [7:0] data1, mask1;
  real        bl1 [8];
  real        blb1 [8];

  logic [7:0] bl0_b, blb0_b, bl1_b, blb1_b;

  int errors = 0;
  int checks = 0;

  write_driver_seq dut0 (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req0), .wr_ready(wr_ready0),
    .data_in(data0), .wmask(mask0), .wl_en(wl_en0), .busy(busy0), .done(done0),
    .bl_wr(bl0), .blb_wr(blb0)
  );

  write_driver_seq #(.COLS(8), .PRE_CYCLES(3), .DRIVE_CYCLES(4), .VDD(1.0)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req1), .wr_ready(wr_ready1),
    .data_in(data1), .wmask(mask1), .wl_en(wl_en1), .busy(busy1), .done(done1),
    .bl_wr(bl1), .blb_wr(blb1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic lvl(input real v);
    if (v == 1.0) return 1'b1;
    else if (v == 0.0) return 1'b0;
    else return 1'bx;
  endfunction

  always_comb begin
    bl0_b = '0; blb0_b = '0; bl1_b = '0; blb1_b = '0;
    for (int i = 0; i < 8; i++) begin
      bl0_b[i]  = lvl(bl0[i]);
      blb0_b[i] = lvl(blb0[i]);
      bl1_b[i]  = lvl(bl1[i]);
      blb1_b[i] = lvl(blb1[i]);
    end
  end

  task automatic start_write(input logic [7:0] d, input logic [7:0] m);
    @(negedge clk);
    wr_req0 = 1'b1; data0 = d; mask0 = m;
    @(posedge clk);
    #1 wr_req0 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({wl_en0, busy0, done0, wr_ready0} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_ctrl: got wl/busy/done/rdy=%b want 0001", {wl_en0, busy0, done0, wr_ready0});
    end
    checks++;
    if (bl0_b !== 8'hFF || blb0_b !== 8'hFF) begin
      errors++;
      $display("FAIL reset_bl: got bl=%h blb=%h want FF FF", bl0_b, blb0_b);
    end
    checks++;
    if ({wl_en1, busy1, done1, wr_ready1} !== 4'b0001 || bl1_b !== 8'hFF || blb1_b !== 8'hFF) begin
      errors++;
      $display("FAIL reset_dut1: got ctrl=%b bl=%h blb=%h want 0001 FF FF",
               {wl_en1, busy1, done1, wr_ready1}, bl1_b, blb1_b);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [4:0] wlx, donex, busyx;
    logic [7:0] blx, blbx;
    wlx = 5'b00110; donex = 5'b01000; busyx = 5'b01111;
    start_write(8'hA5, 8'hFF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      blx  = wlx[k] ? 8'hA5 : 8'hFF;
      blbx = wlx[k] ? 8'h5A : 8'hFF;
      checks++;
      if ({wl_en0, done0, busy0, wr_ready0} !== {wlx[k], donex[k], busyx[k], ~busyx[k]}) begin
        errors++;
        $display("FAIL basic_ctrl k=%0d: got wl/done/busy/rdy=%b want %b", k,
                 {wl_en0, done0, busy0, wr_ready0}, {wlx[k], donex[k], busyx[k], ~busyx[k]});
      end
      checks++;
      if (bl0_b !== blx || blb0_b !== blbx) begin
        errors++;
        $display("FAIL basic_bl k=%0d: got bl=%h blb=%h want %h %h", k, bl0_b, blb0_b, blx, blbx);
      end
    end
  endtask

  task automatic test_masked();
    logic [7:0] dv [2];
    logic [7:0] mv [2];
    logic [7:0] blv [2];
    logic [7:0] blbv [2];
    logic [4:0] wlx, donex;
    logic [7:0] blx, blbx;
    dv[0] = 8'hFF; mv[0] = 8'h0F; blv[0] = 8'hFF; blbv[0] = 8'hF0;
    dv[1] = 8'hFF; mv[1] = 8'h00; blv[1] = 8'hFF; blbv[1] = 8'hFF;
    wlx = 5'b00110; donex = 5'b01000;
    for (int v = 0; v < 2; v++) begin
      start_write(dv[v], mv[v]);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        blx  = wlx[k] ? blv[v]  : 8'hFF;
        blbx = wlx[k] ? blbv[v] : 8'hFF;
        checks++;
        if ({wl_en0, done0} !== {wlx[k], donex[k]} || bl0_b !== blx || blb0_b !== blbx) begin
          errors++;
          $display("FAIL masked v=%0d k=%0d: got wl=%b done=%b bl=%h blb=%h want %b %b %h %h",
                   v, k, wl_en0, done0, bl0_b, blb0_b, wlx[k], donex[k], blx, blbx);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    int n_done, n_busy, n_wl;
    n_done = 0; n_busy = 0; n_wl = 0;
    start_write(8'h3C, 8'hFF);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (done0) n_done++;
      if (busy0) n_busy++;
      if (wl_en0) n_wl++;
      if (k == 1 || k == 2) begin
        checks++;
        if (wl_en0 !== 1'b1 || bl0_b !== 8'h3C || blb0_b !== 8'hC3) begin
          errors++;
          $display("FAIL busy_pattern k=%0d: got wl=%b bl=%h blb=%h want 1 3C C3", k, wl_en0, bl0_b, blb0_b);
        end
      end
      if (k == 1) begin
        wr_req0 = 1'b1;
        data0 = 8'h00;
      end
      if (k == 4) wr_req0 = 1'b0;
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL busy_done_count: got %0d want 1", n_done);
    end
    checks++;
    if (n_busy != 4) begin
      errors++;
      $display("FAIL busy_cycle_count: got %0d want 4", n_busy);
    end
    checks++;
    if (n_wl != 2) begin
      errors++;
      $display("FAIL busy_wl_count: got %0d want 2", n_wl);
    end
  endtask

  task automatic test_reset_mid_drive();
    int n_done;
    n_done = 0;
    start_write(8'h96, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (wl_en0 !== 1'b1 || bl0_b !== 8'h96) begin
      errors++;
      $display("FAIL rstmid_pre: got wl=%b bl=%h want 1 96", wl_en0, bl0_b);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wl_en0, done0, busy0, wr_ready0} !== 4'b0001 || bl0_b !== 8'hFF || blb0_b !== 8'hFF) begin
      errors++;
      $display("FAIL rstmid_async: got ctrl=%b bl=%h blb=%h want 0001 FF FF",
               {wl_en0, done0, busy0, wr_ready0}, bl0_b, blb0_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done0 || busy0) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: got %0d active cycles want 0", n_done);
    end
    start_write(8'h3C, 8'h0F);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (wl_en0 !== 1'b1 || bl0_b !== 8'hFC || blb0_b !== 8'hF3) begin
      errors++;
      $display("FAIL rstmid_after_drive: got wl=%b bl=%h blb=%h want 1 FC F3", wl_en0, bl0_b, blb0_b);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || wl_en0 !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after_done: got done=%b wl=%b want 1 0", done0, wl_en0);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n_wl, n_done, n_ovl, ph;
    logic wx, dx, bx;
    logic [7:0] blx, blbx;
    n_wl = 0; n_done = 0; n_ovl = 0;
    @(negedge clk);
    wr_req1 = 1'b1; data1 = 8'hA5; mask1 = 8'hFF;
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      ph = c % 9;
      wx = (ph >= 3 && ph <= 6);
      dx = (ph == 7);
      bx = (ph != 8);
      blx  = wx ? 8'hA5 : 8'hFF;
      blbx = wx ? 8'h5A : 8'hFF;
      if (wl_en1) n_wl++;
      if (done1) n_done++;
      if (wl_en1 && done1) n_ovl++;
      checks++;
      if ({wl_en1, done1, busy1, wr_ready1} !== {wx, dx, bx, ~bx} || bl1_b !== blx || blb1_b !== blbx) begin
        errors++;
        $display("FAIL b2b c=%0d: got wl/done/busy/rdy=%b bl=%h blb=%h want %b %h %h", c,
                 {wl_en1, done1, busy1, wr_ready1}, bl1_b, blb1_b, {wx, dx, bx, ~bx}, blx, blbx);
      end
    end
    wr_req1 = 1'b0;
    checks++;
    if (n_wl != 12) begin
      errors++;
      $display("FAIL b2b_wl_count: got %0d want 12", n_wl);
    end
    checks++;
    if (n_done != 3) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d want 3", n_done);
    end
    checks++;
    if (n_ovl != 0) begin
      errors++;
      $display("FAIL b2b_overlap: got %0d want 0", n_ovl);
    end
  endtask

  initial begin
    wr_req0 = 1'b0; data0 = 8'h00; mask0 = 8'h00;
    wr_req1 = 1'b0; data1 = 8'h00; mask1 = 8'h00;
    test_reset();
    test_basic();
    test_masked();
    test_busy_ignore();
    test_reset_mid_drive();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
